rtc_read_scheduler: RTL and testbench

RTC_READ_SCHEDULER -- requirements
Module: rtc_read_scheduler

---
 rtl/rtc_read_scheduler_pkg.sv | 38 +++
 rtl/rtc_read_scheduler_if.sv | 31 +++
 rtl/rtc_read_scheduler.sv | 123 ++++++++++++
 tb/tb_rtc_read_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_read_scheduler_pkg.sv
// Shared RTC constants: scheduler state encoding, register indices and
// the default spacing between consecutive register read starts.
package rtc_read_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_WRITE = 3'd4
    } sched_state_t;

    localparam int WAIT_CYCLES_DEF = 36;

    localparam logic [2:0] IDX_SEG  = 3'd0;
    localparam logic [2:0] IDX_MIN  = 3'd1;
    localparam logic [2:0] IDX_HORA = 3'd2;
    localparam logic [2:0] IDX_DIA  = 3'd3;
    localparam logic [2:0] IDX_MES  = 3'd4;
    localparam logic [2:0] IDX_ANIO = 3'd5;

    // Bit k of the result is the start pulse for register index k.
    function automatic logic [5:0] idx_onehot(input logic [2:0] idx);
        logic [5:0] r;
        r = 6'd0;
        case (idx)
            IDX_SEG:  r = 6'b000001;
            IDX_MIN:  r = 6'b000010;
            IDX_HORA: r = 6'b000100;
            IDX_DIA:  r = 6'b001000;
            IDX_MES:  r = 6'b010000;
            IDX_ANIO: r = 6'b100000;
            default:  r = 6'b000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rtc_read_scheduler_if.sv
// Request/grant and read-start signals between the RTC read scheduler,
// the tick source, the programming path and the per-register read FSMs.
interface rtc_read_scheduler_if;
    logic       start_tick;
    logic       write_req;
    logic       write_done;
    logic       do_it_leer_seg;
    logic       do_it_leer_min;
    logic       do_it_leer_hora;
    logic       do_it_leer_dia;
    logic       do_it_leer_mes;
    logic       do_it_leer_anio;
    logic [2:0] reg_sel;
    logic       busy;
    logic       read_done;
    logic       write_grant;

    modport master (
        output start_tick, write_req, write_done,
        input  do_it_leer_seg, do_it_leer_min, do_it_leer_hora,
               do_it_leer_dia, do_it_leer_mes, do_it_leer_anio,
               reg_sel, busy, read_done, write_grant
    );

    modport slave (
        input  start_tick, write_req, write_done,
        output do_it_leer_seg, do_it_leer_min, do_it_leer_hora,
               do_it_leer_dia, do_it_leer_mes, do_it_leer_anio,
               reg_sel, busy, read_done, write_grant
    );
endinterface

// File: rtl/rtc_read_scheduler.sv
// Sequences read starts for the six RTC time/date registers and arbitrates
// the RTC bus against the programming path; a running sweep is never cut short.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | bus free; serve a write first, then a (pending) tick
//   ST_PULSE | one-cycle read start for register idx
//   ST_WAIT  | hold off WAIT_CYCLES cycles while that register is read
//   ST_DONE  | one-cycle read_done after register 5
//   ST_WRITE | programming path owns the bus until write_done
module rtc_read_scheduler
    import rtc_read_scheduler_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_read_scheduler_if.slave  bus
);

    localparam logic [5:0] CNT_LAST = 6'(WAIT_CYCLES - 1);

    sched_state_t state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         tick_pend_q, tick_pend_d;
    logic         write_pend_q, write_pend_d;
    logic         grant_q;
    logic [5:0]   do_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= 6'd0;
            tick_pend_q  <= 1'b0;
            write_pend_q <= 1'b0;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            write_pend_q <= write_pend_d;
            grant_q      <= (state_q == ST_WRITE);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        tick_pend_d  = tick_pend_q;
        write_pend_d = write_pend_q;

        // Requests seen while busy are remembered, repeats collapse to one.
        if (state_q != ST_IDLE && bus.start_tick) begin
            tick_pend_d = 1'b1;
        end
        if ((state_q == ST_PULSE || state_q == ST_WAIT || state_q == ST_DONE) && bus.write_req) begin
            write_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.write_req || write_pend_q) begin
                    state_d      = ST_WRITE;
                    write_pend_d = 1'b0;
                    if (bus.start_tick) begin
                        tick_pend_d = 1'b1;
                    end
                end else if (bus.start_tick || tick_pend_q) begin
                    state_d     = ST_PULSE;
                    idx_d       = IDX_SEG;
                    tick_pend_d = 1'b0;
                end
            end
            ST_PULSE: begin
                cnt_d   = 6'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == IDX_ANIO) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_WRITE: begin
                // A release in the very first grant cycle is treated as stale.
                if (bus.write_done && grant_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign do_vec = (state_q == ST_PULSE) ? idx_onehot(idx_q) : 6'd0;

    assign bus.do_it_leer_seg  = do_vec[IDX_SEG];
    assign bus.do_it_leer_min  = do_vec[IDX_MIN];
    assign bus.do_it_leer_hora = do_vec[IDX_HORA];
    assign bus.do_it_leer_dia  = do_vec[IDX_DIA];
    assign bus.do_it_leer_mes  = do_vec[IDX_MES];
    assign bus.do_it_leer_anio = do_vec[IDX_ANIO];

    assign bus.reg_sel     = (state_q == ST_PULSE || state_q == ST_WAIT) ? idx_q : 3'd0;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.read_done   = (state_q == ST_DONE);
    assign bus.write_grant = (state_q == ST_WRITE);

endmodule

// File: tb/tb_rtc_read_scheduler.sv
// Directed bench for rtc_read_scheduler: sweep timing, write arbitration,
// tick collapsing and mid-sweep reset, with a per-cycle pulse exclusivity monitor.
module tb_rtc_read_scheduler;

    localparam int W     = 36;
    localparam int SWEEP = 6 * (W + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_read_scheduler_if bus();

    rtc_read_scheduler #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks      = 0;
    int failures    = 0;
    int pulse_count = 0;
    int done_count  = 0;

    logic [5:0] do_v;
    assign do_v = {bus.do_it_leer_anio, bus.do_it_leer_mes, bus.do_it_leer_dia,
                   bus.do_it_leer_hora, bus.do_it_leer_min, bus.do_it_leer_seg};

    always @(negedge clk) begin
        pulse_count += $countones(do_v);
        if (bus.read_done) done_count++;
        checks++;
        if ($countones(do_v) > 1 || (do_v != 6'd0 && bus.write_grant)) begin
            failures++;
            $display("FAIL pulse_exclusive t=%0t do=%b grant=%b required <=1 pulse and none while granted",
                     $time, do_v, bus.write_grant);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks one full sweep starting at the cycle of the seg pulse; optional
    // ticks and a write request are injected at the given sweep offsets.
    task automatic run_sweep(input string tag, input int t1, input int t2, input int t3, input int wreq_j);
        logic [11:0] got, exp;
        logic [5:0]  exp_do;
        logic [2:0]  exp_sel;
        int k, m;
        for (int j = 0; j <= SWEEP; j++) begin
            bus.start_tick = (j == t1 || j == t2 || j == t3);
            if (j == wreq_j) bus.write_req = 1'b1;
            k = j / (W + 1);
            m = j % (W + 1);
            exp_do  = (j < SWEEP && m == 0) ? 6'(1 << k) : 6'd0;
            exp_sel = (j < SWEEP) ? 3'(k) : 3'd0;
            exp = {exp_do, exp_sel, 1'b1, (j == SWEEP), 1'b0};
            got = {do_v, bus.reg_sel, bus.busy, bus.read_done, bus.write_grant};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s j=%0d got do/sel/busy/done/grant=%b required %b", tag, j, got, exp);
            end
            next_cycle();
        end
        bus.start_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        bus.start_tick = 1'b0;
        bus.write_req  = 1'b0;
        bus.write_done = 1'b0;
        #1;
        got = {do_v, bus.reg_sel, bus.busy, bus.read_done, bus.write_grant};
        checks++;
        if (got !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required 0", got);
        end
        bus.start_tick = 1'b1;
        next_cycle();
        next_cycle();
        got = {do_v, bus.reg_sel, bus.busy, bus.read_done, bus.write_grant};
        checks++;
        if (got !== 12'd0) begin
            failures++;
            $display("FAIL reset_hold got=%b required 0", got);
        end
        bus.start_tick = 1'b0;
        reset = 1'b0;
        next_cycle();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_sweep();
        bus.start_tick = 1'b1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_tick_cycle busy=%b required 0", bus.busy);
        end
        next_cycle();
        bus.start_tick = 1'b0;
        run_sweep("sweep", -1, -1, -1, -1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.busy !== 1'b0 || do_v !== 6'd0) begin
                failures++;
                $display("FAIL sweep_after_idle i=%0d busy=%b do=%b required 0", i, bus.busy, do_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_write_priority();
        bus.write_req  = 1'b1;
        bus.start_tick = 1'b1;
        next_cycle();
        bus.write_req  = 1'b0;
        bus.start_tick = 1'b0;
        bus.write_done = 1'b1;
        checks++;
        if (bus.write_grant !== 1'b1 || bus.busy !== 1'b1 || bus.reg_sel !== 3'd0) begin
            failures++;
            $display("FAIL write_grant_first grant=%b busy=%b sel=%0d required 1,1,0",
                     bus.write_grant, bus.busy, bus.reg_sel);
        end
        next_cycle();
        bus.write_done = 1'b0;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (bus.write_grant !== 1'b1) begin
                failures++;
                $display("FAIL write_grant_hold i=%0d grant=%b required 1", i, bus.write_grant);
            end
            next_cycle();
        end
        bus.write_done = 1'b1;
        checks++;
        if (bus.write_grant !== 1'b1) begin
            failures++;
            $display("FAIL write_grant_release_cycle grant=%b required 1", bus.write_grant);
        end
        next_cycle();
        bus.write_done = 1'b0;
        checks++;
        if (bus.write_grant !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL write_back_idle grant=%b busy=%b required 0,0", bus.write_grant, bus.busy);
        end
        next_cycle();
        run_sweep("pending_tick_sweep", -1, -1, -1, -1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL pending_tick_idle busy=%b required 0", bus.busy);
        end
        next_cycle();
    endtask

    task automatic test_write_during_sweep();
        bus.start_tick = 1'b1;
        next_cycle();
        bus.start_tick = 1'b0;
        run_sweep("sweep_with_wreq", -1, -1, -1, 2 * (W + 1) + 5);
        checks++;
        if (bus.busy !== 1'b0 || bus.write_grant !== 1'b0) begin
            failures++;
            $display("FAIL wreq_idle_after_done busy=%b grant=%b required 0,0", bus.busy, bus.write_grant);
        end
        next_cycle();
        checks++;
        if (bus.write_grant !== 1'b1) begin
            failures++;
            $display("FAIL wreq_grant_after_sweep grant=%b required 1", bus.write_grant);
        end
        bus.write_req = 1'b0;
        next_cycle();
        bus.write_done = 1'b1;
        next_cycle();
        bus.write_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL wreq_release_idle i=%0d busy=%b required 0", i, bus.busy);
            end
            next_cycle();
        end
    endtask

    task automatic test_tick_collapse();
        pulse_count = 0;
        bus.start_tick = 1'b1;
        next_cycle();
        bus.start_tick = 1'b0;
        run_sweep("collapse_first", 3, 50, 150, -1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL collapse_gap busy=%b required 0", bus.busy);
        end
        next_cycle();
        run_sweep("collapse_second", -1, -1, -1, -1);
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL collapse_no_third i=%0d busy=%b required 0", i, bus.busy);
            end
            next_cycle();
        end
        checks++;
        if (pulse_count != 12) begin
            failures++;
            $display("FAIL collapse_pulse_total got=%0d required 12", pulse_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        int dones;
        dones = done_count;
        bus.start_tick = 1'b1;
        next_cycle();
        bus.start_tick = 1'b0;
        for (int j = 0; j < 3 * (W + 1) + 10; j++) next_cycle();
        checks++;
        if (bus.busy !== 1'b1 || bus.reg_sel !== 3'd3) begin
            failures++;
            $display("FAIL midreset_pre busy=%b sel=%0d required 1,3", bus.busy, bus.reg_sel);
        end
        #2 reset = 1'b1;
        #1;
        got = {do_v, bus.reg_sel, bus.busy, bus.read_done, bus.write_grant};
        checks++;
        if (got !== 12'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b required 0", got);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (bus.busy !== 1'b0 || do_v !== 6'd0 || bus.read_done !== 1'b0) begin
                failures++;
                $display("FAIL midreset_stay_idle i=%0d busy=%b do=%b done=%b required 0",
                         i, bus.busy, do_v, bus.read_done);
            end
            next_cycle();
        end
        checks++;
        if (done_count != dones) begin
            failures++;
            $display("FAIL midreset_no_read_done got=%0d required %0d", done_count, dones);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 4; i++) next_cycle();
        test_sweep();
        test_write_priority();
        test_write_during_sweep();
        test_tick_collapse();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
